tick_gen: RTL and testbench
===========================

TICK_GEN -- requirements
Module: tick_gen

Interface
REQ-001 Parameter NUM_CH, default 3: number of independent divider channels, 1..8.
REQ-002 Parameter CNT_W, default 26: width of each channel counter and divisor register.
REQ-003 Parameter DIV_DEFAULT, default 49_999_999: divisor loaded into every channel at reset; SHALL fit in CNT_W bits.
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 enable  input  1  global count enable.
REQ-007 sync_clr  input  1  synchronous phase-align: clears all counters and outputs.
REQ-008 load  input  1  one-cycle strobe: write load_div into channel load_ch.
REQ-009 load_ch  input  3  channel index for load.
REQ-010 load_div  input  CNT_W  new divisor value.
REQ-011 mode  input  NUM_CH  per channel: 0 = toggle (square wave), 1 = pulse (one-cycle strobe).
REQ-012 ch_out  output  NUM_CH  registered per-channel output.
REQ-013 tick  output  NUM_CH  registered per-channel terminal-count strobe, independent of mode.

Function
REQ-014 Each channel SHALL hold a divisor div[i] and a counter cnt[i], both CNT_W bits.
REQ-015 Counting (enable=1): if cnt[i] >= div[i], cnt[i] <= 0 and a terminal event occurs; otherwise cnt[i] <= cnt[i]+1.
REQ-016 Event period SHALL be div[i]+1 clk cycles; tick[i] SHALL be high for exactly the one cycle following each event edge.
REQ-017 Toggle mode: ch_out[i] SHALL invert on each event, giving output period 2*(div[i]+1) cycles.
REQ-018 Pulse mode: ch_out[i] SHALL equal tick[i]; it SHALL be 0 in every non-event cycle.
REQ-019 div[i]=0: event every cycle; toggle mode gives clk/2; pulse mode holds ch_out[i] and tick[i] at 1 continuously.
REQ-020 enable=0: cnt and toggle-mode ch_out SHALL hold; tick and pulse-mode ch_out SHALL be 0.
REQ-021 load=1 with load_ch < NUM_CH: div[load_ch] <= load_div, cnt[load_ch] <= 0, ch_out[load_ch] <= 0, tick[load_ch] <= 0, in the same edge, regardless of enable; other channels unaffected.
REQ-022 load=1 with load_ch >= NUM_CH SHALL be ignored with no state change.
REQ-023 sync_clr=1: all cnt, ch_out, tick <= 0; div registers retained; counting resumes next cycle with cnt=0 on all channels, so channels of equal divisor stay phase-aligned.
REQ-024 Priority, highest first: reset, sync_clr, load, count; sync_clr and load in the same cycle: sync_clr applies and load is discarded.
REQ-025 Mode change on a channel SHALL take effect at the next edge: switching to pulse forces ch_out[i] to 0 unless an event occurs that cycle; switching to toggle resumes from ch_out[i]=0.
REQ-026 Counter comparison SHALL use >= so that no state wraps past div; cnt never exceeds div after the first event.

Reset
REQ-027 On reset: every div[i] = DIV_DEFAULT, every cnt[i] = 0, ch_out = 0, tick = 0, effective immediately and independent of clk.
REQ-028 Reset asserted mid-count SHALL discard all loaded divisors and count progress; first event after release occurs DIV_DEFAULT+1 enabled cycles later.

Verification (NUM_CH=3, CNT_W=8, DIV_DEFAULT=3)
REQ-029 Reset release, enable=1, mode=000 -> tick[i] high every 4th cycle; ch_out toggles with period 8 on all channels, in phase.
REQ-030 load ch1 div=0, mode[1]=1 -> from next cycle ch_out[1]=tick[1]=1 continuously; ch0, ch2 unaffected.
REQ-031 load ch2 div=9 mid-count, toggle mode -> ch_out[2] cleared; first tick[2] 10 cycles after the load edge; ch_out[2] period 20.
REQ-032 enable low for 5 cycles at cnt=2 -> no ticks, toggle outputs frozen; first tick 2 cycles after enable returns.
REQ-033 sync_clr and load(ch0, div=5) same cycle -> all counters 0, div0 remains 3, all channels tick together 4 cycles later.
REQ-034 load_ch=5 strobe -> no change on any output or divisor; asynchronous reset between edges -> ch_out and tick go to 0 immediately.

Source files
------------

// File: rtl/tick_gen_if.sv
// Control and output bundle for tick_gen: divisor loading, mode select, enable/clear
// and the per-channel registered outputs.
interface tick_gen_if #(
    parameter int unsigned NUM_CH = 3,
    parameter int unsigned CNT_W  = 26
);
    logic              enable;
    logic              sync_clr;
    logic              load;
    logic [2:0]        load_ch;
    logic [CNT_W-1:0]  load_div;
    logic [NUM_CH-1:0] mode;
    logic [NUM_CH-1:0] ch_out;
    logic [NUM_CH-1:0] tick;

    modport master (
        output enable, sync_clr, load, load_ch, load_div, mode,
        input  ch_out, tick
    );

    modport slave (
        input  enable, sync_clr, load, load_ch, load_div, mode,
        output ch_out, tick
    );
endinterface

// File: rtl/tick_gen.sv
// Multi-channel programmable divider: each channel counts to its divisor and emits a
// terminal-count strobe, driving either a square wave (toggle) or a one-cycle pulse.
module tick_gen #(
    parameter int unsigned NUM_CH      = 3,
    parameter int unsigned CNT_W       = 26,
    parameter int unsigned DIV_DEFAULT = 49_999_999
) (
    input logic        clk,
    input logic        reset,
    tick_gen_if.slave  bus
);
    localparam logic [CNT_W-1:0] DivInit = CNT_W'(DIV_DEFAULT);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    logic [CNT_W-1:0]  div_q [NUM_CH];
    logic [CNT_W-1:0]  div_d [NUM_CH];
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [NUM_CH-1:0] out_q, out_d;
    logic [NUM_CH-1:0] tick_q, tick_d;
    logic [NUM_CH-1:0] mode_q;
    logic [NUM_CH-1:0] evt;
    logic [NUM_CH-1:0] load_hit;
    logic [NUM_CH-1:0] prev_out;

    // Out-of-range load_ch never matches any channel, so such loads are dropped.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            evt[i]      = (cnt_q[i] >= div_q[i]);
            load_hit[i] = bus.load && (bus.load_ch == 3'(i));
            // Leaving pulse mode restarts the square wave from low.
            prev_out[i] = mode_q[i] ? 1'b0 : out_q[i];
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            div_d[i]  = div_q[i];
            cnt_d[i]  = cnt_q[i];
            out_d[i]  = out_q[i];
            tick_d[i] = 1'b0;
            if (bus.sync_clr) begin
                cnt_d[i] = '0;
                out_d[i] = 1'b0;
            end else if (load_hit[i]) begin
                div_d[i] = bus.load_div;
                cnt_d[i] = '0;
                out_d[i] = 1'b0;
            end else if (bus.enable) begin
                cnt_d[i]  = evt[i] ? '0 : cnt_q[i] + CntOne;
                tick_d[i] = evt[i];
                out_d[i]  = bus.mode[i] ? evt[i] : (prev_out[i] ^ evt[i]);
            end else begin
                out_d[i] = bus.mode[i] ? 1'b0 : prev_out[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                div_q[i] <= DivInit;
                cnt_q[i] <= '0;
            end
            out_q  <= '0;
            tick_q <= '0;
            mode_q <= '0;
        end else begin
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            tick_q <= tick_d;
            mode_q <= bus.mode;
        end
    end

    assign bus.ch_out = out_q;
    assign bus.tick   = tick_q;
endmodule

// File: tb/tb_tick_gen.sv
// Directed bench for tick_gen (3 channels, 8-bit, default divisor 3): the driver queues
// hand-derived expectations per edge, a monitor compares them on the falling edge.
module tb_tick_gen;
    logic clk = 1'b0;
    logic reset;

    tick_gen_if #(.NUM_CH(3), .CNT_W(8)) bus ();

    tick_gen #(.NUM_CH(3), .CNT_W(8), .DIV_DEFAULT(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    logic [5:0] exp_q [$];
    string      name_q [$];
    int         checks = 0;
    int         errors = 0;
    event       chk_ev;

    task automatic push(input logic [2:0] eo, input logic [2:0] et, input string nm);
        exp_q.push_back({eo, et});
        name_q.push_back(nm);
    endtask

    task automatic edge_chk(input logic [2:0] eo, input logic [2:0] et, input string nm);
        @(posedge clk);
        #1;
        push(eo, et, nm);
    endtask

    // Monitor: compares one queued expectation per falling edge (or on an explicit poke).
    always begin
        logic [5:0] e;
        string      nm;
        @(negedge clk or chk_ev);
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            checks++;
            if ({bus.ch_out, bus.tick} !== e) begin
                errors++;
                $display("FAIL %s: ch_out=%b tick=%b required ch_out=%b tick=%b",
                         nm, bus.ch_out, bus.tick, e[5:3], e[2:0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] eo, et;
        logic       o0, t0, o2, t2;

        reset        = 1'b1;
        bus.enable   = 1'b0;
        bus.sync_clr = 1'b0;
        bus.load     = 1'b0;
        bus.load_ch  = 3'd0;
        bus.load_div = 8'd0;
        bus.mode     = 3'b000;
        push(3'b000, 3'b000, "reset_state");
        @(posedge clk);
        #1;
        reset      = 1'b0;
        bus.enable = 1'b1;

        // All channels at default divisor 3: tick every 4th edge, square wave of period 8.
        for (int k = 1; k <= 16; k++) begin
            t0 = (k % 4 == 0);
            o0 = ((k / 4) % 2 == 1);
            edge_chk({3{o0}}, {3{t0}}, $sformatf("default_e%0d", k));
        end

        // ch1 -> divisor 0 in pulse mode at edge 17; ch2 -> divisor 9 at edge 26.
        for (int k = 17; k <= 62; k++) begin
            bus.load     = (k == 17) || (k == 26);
            bus.load_ch  = (k == 17) ? 3'd1 : 3'd2;
            bus.load_div = (k == 17) ? 8'd0 : 8'd9;
            if (k == 17) bus.mode = 3'b010;
            t0 = (k % 4 == 0);
            o0 = ((k / 4) % 2 == 1);
            if (k < 26) begin
                t2 = t0;
                o2 = o0;
            end else begin
                t2 = (k >= 36) && ((k - 36) % 10 == 0);
                o2 = (((k - 26) / 10) % 2 == 1);
            end
            eo = {o2, (k != 17), o0};
            et = {t2, (k != 17), t0};
            edge_chk(eo, et, $sformatf("load_e%0d", k));
        end
        bus.load = 1'b0;

        // Enable off with ch0 at cnt=2: toggles frozen high, pulse output low.
        bus.enable = 1'b0;
        for (int k = 63; k <= 67; k++) edge_chk(3'b101, 3'b000, $sformatf("hold_e%0d", k));
        bus.enable = 1'b1;
        edge_chk(3'b111, 3'b010, "resume_e68");
        edge_chk(3'b110, 3'b011, "resume_e69");
        edge_chk(3'b110, 3'b010, "resume_e70");
        edge_chk(3'b010, 3'b110, "resume_e71");
        edge_chk(3'b010, 3'b010, "resume_e72");

        // Restore ch1/ch2 to divisor 3 in toggle mode, then sync_clr collides with a load.
        bus.mode     = 3'b000;
        bus.load     = 1'b1;
        bus.load_ch  = 3'd1;
        bus.load_div = 8'd3;
        edge_chk(3'b001, 3'b001, "reload_ch1");
        bus.load_ch  = 3'd2;
        edge_chk(3'b001, 3'b000, "reload_ch2");
        bus.sync_clr = 1'b1;
        bus.load_ch  = 3'd0;
        bus.load_div = 8'd5;
        edge_chk(3'b000, 3'b000, "sync_clr_vs_load");
        bus.sync_clr = 1'b0;
        bus.load     = 1'b0;

        // Phase-aligned restart; an out-of-range load at edge 84 must change nothing.
        for (int k = 76; k <= 87; k++) begin
            bus.load     = (k == 84);
            bus.load_ch  = 3'd5;
            bus.load_div = 8'd1;
            t0 = ((k - 75) % 4 == 0);
            o0 = (((k - 75) / 4) % 2 == 1);
            edge_chk({3{o0}}, {3{t0}}, $sformatf("aligned_e%0d", k));
        end
        bus.load = 1'b0;

        // Asynchronous reset between edges must clear outputs without a clock.
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        push(3'b000, 3'b000, "async_reset");
        ->chk_ev;
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int k = 1; k <= 8; k++) begin
            t0 = (k % 4 == 0);
            o0 = ((k / 4) % 2 == 1);
            edge_chk({3{o0}}, {3{t0}}, $sformatf("post_reset_e%0d", k));
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
